counter_lockstep_checker: RTL and testbench

// Downstream consumer of the three ALU counter outputs (alucount, alucount2, alucount3).

---
 rtl/counter_lockstep_checker_if.sv | 21 ++
 rtl/counter_lockstep_checker.sv | 178 +++++++++++++++++
 tb/tb_counter_lockstep_checker.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/counter_lockstep_checker_if.sv
// Snapshot handshake bundle for the lockstep checker.
// The checker drives the snapshot (master) and a downstream consumer accepts it (slave).
interface counter_lockstep_checker_if #(
  parameter int WIDTH = 8
);
  logic                 snap_valid;
  logic                 snap_ready;
  logic [3*WIDTH-1:0]   snap_data;

  modport master (
    output snap_valid,
    output snap_data,
    input  snap_ready
  );

  modport slave (
    input  snap_valid,
    input  snap_data,
    output snap_ready
  );
endinterface

// File: rtl/counter_lockstep_checker.sv
// Lockstep checker for three redundant counters.
// S1 samples the three counts, S2 holds the bitwise 2-of-3 vote and the error pulses.
// Errors (disagreement or a voted step other than +1) feed a sticky flag, a saturating
// counter, a WARMUP/ARMED/FAULT state machine and a one-deep snapshot of the first
// faulting raw sample triple.
module counter_lockstep_checker #(
  parameter int WIDTH    = 8,
  parameter int WARMUP   = 2,
  parameter int ERRCNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     cnt_a,
  input  logic [WIDTH-1:0]     cnt_b,
  input  logic [WIDTH-1:0]     cnt_c,
  input  logic                 clr_err,
  output logic [WIDTH-1:0]     voted,
  output logic                 voted_vld,
  output logic                 mismatch,
  output logic                 seq_err,
  output logic                 err_sticky,
  output logic [ERRCNT_W-1:0]  err_count,
  output logic [1:0]           fsm_state,
  counter_lockstep_checker_if.master snap
);

  typedef enum logic [1:0] {
    ST_WARMUP = 2'b00,
    ST_ARMED  = 2'b01,
    ST_FAULT  = 2'b10
  } state_t;

  // Warm-up counter runs 0..WARMUP-1 once the vote is valid.
  localparam int WC_W = (WARMUP > 1) ? $clog2(WARMUP) : 1;
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(WARMUP - 1);

  // Bitwise 2-of-3 majority.
  function automatic logic [WIDTH-1:0] maj3(input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b,
                                            input logic [WIDTH-1:0] c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Increment that sticks at all-ones.
  function automatic logic [ERRCNT_W-1:0] sat_inc(input logic [ERRCNT_W-1:0] v);
    return (&v) ? v : v + ERRCNT_W'(1);
  endfunction

  logic [WIDTH-1:0]    a_p1, b_p1, c_p1;
  logic                vld_p1;
  logic [WIDTH-1:0]    voted_p2;
  logic                vld_p2;
  logic                mism_p2;
  logic                seq_p2;
  state_t              state_p2;
  logic [WC_W-1:0]     wcnt_p2;
  logic [ERRCNT_W-1:0] err_count_p2;
  logic                err_sticky_p2;
  logic                snap_valid_p2;
  logic [3*WIDTH-1:0]  snap_data_p2;

  logic [WIDTH-1:0]    vote_p1;
  logic                mism_p1;
  logic                seq_p1;
  logic                err_p1;
  logic                chk_en;

  // Vote and error detection on the S1 samples; voted_p2 is the previous vote here.
  always_comb begin
    vote_p1 = maj3(a_p1, b_p1, c_p1);
    mism_p1 = vld_p1 & ((a_p1 != b_p1) | (a_p1 != c_p1));
    chk_en  = vld_p2 & (state_p2 != ST_WARMUP);
    seq_p1  = chk_en & (vote_p1 != voted_p2 + WIDTH'(1));
    err_p1  = mism_p1 | seq_p1;
  end

  // ---- Stage 1: sample the three counter outputs ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_p1   <= '0;
      b_p1   <= '0;
      c_p1   <= '0;
      vld_p1 <= 1'b0;
    end else begin
      a_p1   <= cnt_a;
      b_p1   <= cnt_b;
      c_p1   <= cnt_c;
      vld_p1 <= 1'b1;
    end
  end

  // ---- Stage 2: register vote, validity and the error pulses ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      voted_p2 <= '0;
      vld_p2   <= 1'b0;
      mism_p2  <= 1'b0;
      seq_p2   <= 1'b0;
    end else begin
      voted_p2 <= vote_p1;
      vld_p2   <= vld_p1;
      mism_p2  <= mism_p1;
      seq_p2   <= seq_p1;
    end
  end

  // Error bookkeeping: clear wins over accumulation, but a same-cycle error restarts at 1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_count_p2  <= '0;
      err_sticky_p2 <= 1'b0;
    end else if (clr_err) begin
      err_count_p2  <= err_p1 ? ERRCNT_W'(1) : '0;
      err_sticky_p2 <= err_p1;
    end else if (err_p1) begin
      err_count_p2  <= sat_inc(err_count_p2);
      err_sticky_p2 <= 1'b1;
    end
  end

  // Checker state: wait out warm-up, then watch for faults until cleared.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_p2 <= ST_WARMUP;
      wcnt_p2  <= '0;
    end else begin
      case (state_p2)
        ST_WARMUP: begin
          if (vld_p2) begin
            if (wcnt_p2 == WC_LAST) begin
              state_p2 <= ST_ARMED;
            end else begin
              wcnt_p2 <= wcnt_p2 + WC_W'(1);
            end
          end
        end
        ST_ARMED: begin
          if (err_p1) begin
            state_p2 <= ST_FAULT;
          end
        end
        ST_FAULT: begin
          if (clr_err && !err_p1) begin
            state_p2 <= ST_ARMED;
          end
        end
        default: begin
          state_p2 <= ST_WARMUP;
          wcnt_p2  <= '0;
        end
      endcase
    end
  end

  // One-deep snapshot; a capture in the same cycle as an accepted handshake replaces it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      snap_valid_p2 <= 1'b0;
      snap_data_p2  <= '0;
    end else if (err_p1 && (!snap_valid_p2 || snap.snap_ready)) begin
      snap_valid_p2 <= 1'b1;
      snap_data_p2  <= {a_p1, b_p1, c_p1};
    end else if (snap_valid_p2 && snap.snap_ready) begin
      snap_valid_p2 <= 1'b0;
    end
  end

  assign voted           = voted_p2;
  assign voted_vld       = vld_p2;
  assign mismatch        = mism_p2;
  assign seq_err         = seq_p2;
  assign err_sticky      = err_sticky_p2;
  assign err_count       = err_count_p2;
  assign fsm_state       = state_p2;
  assign snap.snap_valid = snap_valid_p2;
  assign snap.snap_data  = snap_data_p2;

endmodule

// File: tb/tb_counter_lockstep_checker.sv
// Directed bench for counter_lockstep_checker (WIDTH=8, WARMUP=2, ERRCNT_W=8).
module tb_counter_lockstep_checker;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  cnt_a, cnt_b, cnt_c;
  logic        clr_err;
  logic [7:0]  voted;
  logic        voted_vld, mismatch, seq_err, err_sticky;
  logic [7:0]  err_count;
  logic [1:0]  fsm_state;

  int checks   = 0;
  int failures = 0;
  logic [7:0] cur;

  counter_lockstep_checker_if #(.WIDTH(8)) sif ();

  counter_lockstep_checker #(.WIDTH(8), .WARMUP(2), .ERRCNT_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .cnt_a      (cnt_a),
    .cnt_b      (cnt_b),
    .cnt_c      (cnt_c),
    .clr_err    (clr_err),
    .voted      (voted),
    .voted_vld  (voted_vld),
    .mismatch   (mismatch),
    .seq_err    (seq_err),
    .err_sticky (err_sticky),
    .err_count  (err_count),
    .fsm_state  (fsm_state),
    .snap       (sif)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    cnt_a = a;
    cnt_b = b;
    cnt_c = c;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; clr_err = 1'b0; sif.snap_ready = 1'b0;
    cnt_a = 8'h00; cnt_b = 8'h00; cnt_c = 8'h00;
    #3 reset = 1'b0;
    #1;
    checks++; if (voted !== 8'h00) begin failures++; $display("FAIL rst_voted got=%0h exp=0", voted); end
    checks++; if (voted_vld !== 1'b0) begin failures++; $display("FAIL rst_vld got=%0b exp=0", voted_vld); end
    checks++; if (fsm_state !== 2'b00) begin failures++; $display("FAIL rst_state got=%0d exp=0", fsm_state); end
    checks++; if (err_count !== 8'h00) begin failures++; $display("FAIL rst_errcnt got=%0h exp=0", err_count); end
    checks++; if (sif.snap_valid !== 1'b0) begin failures++; $display("FAIL rst_snapv got=%0b exp=0", sif.snap_valid); end
    tick();
    tick();
    checks++; if ({mismatch, seq_err, err_sticky, sif.snap_data} !== 27'h0) begin
      failures++; $display("FAIL rst_held got=%0h exp=0", {mismatch, seq_err, err_sticky, sif.snap_data});
    end
    reset = 1'b1;
  endtask

  task automatic test_count();
    for (int n = 1; n <= 8; n++) begin
      push(8'(n - 1), 8'(n - 1), 8'(n - 1));
      checks++; if (voted_vld !== (n >= 2)) begin failures++; $display("FAIL cnt_vld n=%0d got=%0b exp=%0b", n, voted_vld, (n >= 2)); end
      if (n >= 2) begin
        checks++; if (voted !== 8'(n - 2)) begin failures++; $display("FAIL cnt_voted n=%0d got=%0h exp=%0h", n, voted, 8'(n - 2)); end
      end
      checks++; if (fsm_state !== ((n >= 4) ? 2'b01 : 2'b00)) begin
        failures++; $display("FAIL cnt_state n=%0d got=%0d exp=%0d", n, fsm_state, (n >= 4) ? 1 : 0);
      end
      checks++; if ((mismatch | seq_err) !== 1'b0) begin failures++; $display("FAIL cnt_err n=%0d got=%0b exp=0", n, mismatch | seq_err); end
    end
    checks++; if ({err_sticky, err_count, sif.snap_valid} !== 10'h0) begin
      failures++; $display("FAIL cnt_clean got=%0h exp=0", {err_sticky, err_count, sif.snap_valid});
    end
    cur = 8'h08;
  endtask

  task automatic test_mismatch();
    while (cur != 8'h10) begin push(cur, cur, cur); cur++; end
    push(8'h10, 8'h55, 8'h10);
    push(8'h11, 8'h11, 8'h11);
    checks++; if (voted !== 8'h10) begin failures++; $display("FAIL mm_voted got=%0h exp=10", voted); end
    checks++; if (mismatch !== 1'b1) begin failures++; $display("FAIL mm_pulse got=%0b exp=1", mismatch); end
    checks++; if (seq_err !== 1'b0) begin failures++; $display("FAIL mm_seq got=%0b exp=0", seq_err); end
    checks++; if (fsm_state !== 2'b10) begin failures++; $display("FAIL mm_state got=%0d exp=2", fsm_state); end
    checks++; if (err_count !== 8'h01) begin failures++; $display("FAIL mm_errcnt got=%0h exp=1", err_count); end
    checks++; if (sif.snap_valid !== 1'b1) begin failures++; $display("FAIL mm_snapv got=%0b exp=1", sif.snap_valid); end
    checks++; if (sif.snap_data !== 24'h105510) begin failures++; $display("FAIL mm_snapd got=%0h exp=105510", sif.snap_data); end
    push(8'h12, 8'h12, 8'h12);
    checks++; if ({mismatch, err_count} !== 9'h001) begin failures++; $display("FAIL mm_once got=%0h exp=001", {mismatch, err_count}); end
    sif.snap_ready = 1'b1;
    push(8'h13, 8'h13, 8'h13);
    sif.snap_ready = 1'b0;
    checks++; if (sif.snap_valid !== 1'b0) begin failures++; $display("FAIL mm_snapack got=%0b exp=0", sif.snap_valid); end
    cur = 8'h14;
  endtask

  task automatic test_wrap_and_seq();
    int errs;
    clr_err = 1'b1;
    push(cur, cur, cur); cur++;
    clr_err = 1'b0;
    checks++; if (fsm_state !== 2'b01) begin failures++; $display("FAIL clr_state got=%0d exp=1", fsm_state); end
    checks++; if ({err_sticky, err_count} !== 9'h0) begin failures++; $display("FAIL clr_err got=%0h exp=0", {err_sticky, err_count}); end
    errs = 0;
    for (int i = 0; i < 237; i++) begin
      push(cur, cur, cur); cur++;
      if (mismatch | seq_err) errs++;
    end
    checks++; if (errs != 0) begin failures++; $display("FAIL wrap_pulses got=%0d exp=0", errs); end
    checks++; if (err_count !== 8'h00) begin failures++; $display("FAIL wrap_errcnt got=%0h exp=0", err_count); end
    while (cur != 8'h20) begin push(cur, cur, cur); cur++; end
    push(8'h20, 8'h20, 8'h20);
    push(8'h20, 8'h20, 8'h20);
    push(8'h21, 8'h21, 8'h21);
    checks++; if (seq_err !== 1'b1) begin failures++; $display("FAIL seq_pulse got=%0b exp=1", seq_err); end
    checks++; if (mismatch !== 1'b0) begin failures++; $display("FAIL seq_mm got=%0b exp=0", mismatch); end
    checks++; if (err_count !== 8'h01) begin failures++; $display("FAIL seq_errcnt got=%0h exp=1", err_count); end
    checks++; if (fsm_state !== 2'b10) begin failures++; $display("FAIL seq_state got=%0d exp=2", fsm_state); end
    checks++; if (sif.snap_data !== 24'h202020) begin failures++; $display("FAIL seq_snapd got=%0h exp=202020", sif.snap_data); end
    push(8'h22, 8'h22, 8'h22);
    checks++; if ({seq_err, err_count} !== 9'h001) begin failures++; $display("FAIL seq_once got=%0h exp=001", {seq_err, err_count}); end
    cur = 8'h23;
  endtask

  task automatic test_snap_hold();
    clr_err = 1'b1; sif.snap_ready = 1'b1;
    push(8'h23, 8'h23, 8'h23);
    clr_err = 1'b0; sif.snap_ready = 1'b0;
    checks++; if ({sif.snap_valid, err_count, fsm_state} !== 11'h001) begin
      failures++; $display("FAIL hold_pre got=%0h exp=001", {sif.snap_valid, err_count, fsm_state});
    end
    push(8'h24, 8'h24, 8'h24);
    push(8'h25, 8'h01, 8'h25);
    push(8'h26, 8'h26, 8'h26);
    push(8'h27, 8'h27, 8'h02);
    push(8'h28, 8'h28, 8'h28);
    push(8'h03, 8'h29, 8'h29);
    push(8'h2A, 8'h2A, 8'h2A);
    checks++; if (err_count !== 8'h03) begin failures++; $display("FAIL hold_errcnt got=%0h exp=3", err_count); end
    checks++; if (sif.snap_data !== 24'h250125) begin failures++; $display("FAIL hold_snapd got=%0h exp=250125", sif.snap_data); end
    checks++; if ({sif.snap_valid, fsm_state} !== 3'b110) begin failures++; $display("FAIL hold_state got=%0b exp=110", {sif.snap_valid, fsm_state}); end
    sif.snap_ready = 1'b1;
    push(8'h2B, 8'h2B, 8'h2B);
    sif.snap_ready = 1'b0;
    checks++; if (sif.snap_valid !== 1'b0) begin failures++; $display("FAIL hold_ack got=%0b exp=0", sif.snap_valid); end
    cur = 8'h2C;
  endtask

  task automatic test_back_to_back();
    push(8'h2C, 8'h00, 8'h2C);
    push(8'h2D, 8'h2D, 8'h2D);
    checks++; if ({sif.snap_valid, sif.snap_data} !== 25'h12C002C) begin
      failures++; $display("FAIL b2b_first got=%0h exp=12c002c", {sif.snap_valid, sif.snap_data});
    end
    push(8'h2E, 8'h2E, 8'h11);
    sif.snap_ready = 1'b1;
    push(8'h2F, 8'h2F, 8'h2F);
    sif.snap_ready = 1'b0;
    checks++; if ({sif.snap_valid, sif.snap_data} !== 25'h12E2E11) begin
      failures++; $display("FAIL b2b_new got=%0h exp=12e2e11", {sif.snap_valid, sif.snap_data});
    end
    checks++; if (err_count !== 8'h05) begin failures++; $display("FAIL b2b_errcnt got=%0h exp=5", err_count); end
    push(8'h30, 8'h30, 8'h30);
    checks++; if ({sif.snap_valid, sif.snap_data} !== 25'h12E2E11) begin
      failures++; $display("FAIL b2b_held got=%0h exp=12e2e11", {sif.snap_valid, sif.snap_data});
    end
    cur = 8'h31;
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 300; i++) begin
      push(cur, ~cur, cur); cur++;
    end
    checks++; if (err_count !== 8'hFF) begin failures++; $display("FAIL sat_errcnt got=%0h exp=ff", err_count); end
    checks++; if ({err_sticky, fsm_state} !== 3'b110) begin failures++; $display("FAIL sat_state got=%0b exp=110", {err_sticky, fsm_state}); end
    clr_err = 1'b1;
    push(cur, ~cur, cur); cur++;
    clr_err = 1'b0;
    checks++; if (err_count !== 8'h01) begin failures++; $display("FAIL clrerr_cnt got=%0h exp=1", err_count); end
    checks++; if ({err_sticky, fsm_state} !== 3'b110) begin failures++; $display("FAIL clrerr_state got=%0b exp=110", {err_sticky, fsm_state}); end
  endtask

  task automatic test_reset_mid();
    checks++; if ({sif.snap_valid, fsm_state} !== 3'b110) begin failures++; $display("FAIL mid_pre got=%0b exp=110", {sif.snap_valid, fsm_state}); end
    reset = 1'b0;
    #2;
    checks++; if ({voted, voted_vld, mismatch, seq_err} !== 11'h0) begin
      failures++; $display("FAIL mid_data got=%0h exp=0", {voted, voted_vld, mismatch, seq_err});
    end
    checks++; if ({err_sticky, err_count} !== 9'h0) begin failures++; $display("FAIL mid_err got=%0h exp=0", {err_sticky, err_count}); end
    checks++; if (fsm_state !== 2'b00) begin failures++; $display("FAIL mid_state got=%0d exp=0", fsm_state); end
    checks++; if ({sif.snap_valid, sif.snap_data} !== 25'h0) begin
      failures++; $display("FAIL mid_snap got=%0h exp=0", {sif.snap_valid, sif.snap_data});
    end
    tick();
    reset = 1'b1;
  endtask

  initial begin
    test_reset();
    test_count();
    test_mismatch();
    test_wrap_and_seq();
    test_snap_hold();
    test_back_to_back();
    test_saturate();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
